// File: rtl/map_pkg.sv
// Shared constants, frame layout and FSM encoding for the maze map receiver.
package map_pkg;

   localparam int NUM_CELLS  = 21;
   localparam int CELL_W     = 8;
   localparam int MAP_W      = NUM_CELLS * CELL_W;
   localparam int FRAME_BITS = 16;

   // Frame field positions: [15:11] index, [10:8] reserved, [7:0] value.
   localparam int IDX_HI = 15;
   localparam int IDX_LO = 11;
   localparam int RSV_HI = 10;
   localparam int RSV_LO = 8;
   localparam int VAL_HI = 7;
   localparam int VAL_LO = 0;

   // Bit counter: 5 bits, saturating one past a full frame so long frames stay distinguishable.
   localparam int               CNT_W    = 5;
   localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
   localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;

   localparam logic [CELL_W-1:0] RESET_CELL_DEF = 8'h0F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   typedef struct packed {
      logic [IDX_HI-IDX_LO:0] idx;
      logic [RSV_HI-RSV_LO:0] rsv;
      logic [VAL_HI-VAL_LO:0] value;
   } frame_t;

endpackage

// File: rtl/map_receiver_if.sv
// Bundle of the serial link, the frame-sync strobe and the map outputs.
interface map_receiver_if #(
   parameter int MAP_W = map_pkg::MAP_W
);
   logic             sck;
   logic             sdi;
   logic             cs_n;
   logic             frame_sync;
   logic [MAP_W-1:0] map_out;
   logic             update_pend;
   logic [7:0]       err_cnt;

   // Robot controller / video side: drives the link and strobe, observes the map.
   modport master (
      output sck, sdi, cs_n, frame_sync,
      input  map_out, update_pend, err_cnt
   );

   // Receiver side.
   modport slave (
      input  sck, sdi, cs_n, frame_sync,
      output map_out, update_pend, err_cnt
   );
endinterface

// File: rtl/map_receiver_sync_edge.sv
// Two-flop synchronizer with one-cycle rise/fall pulses for an asynchronous input.
module sync_edge #(
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic [2:0] pipe;    // [0],[1] synchronizer, [2] previous synced level
   logic [2:0] primed;  // marks when pipe[2] holds a real sample

   // Shift the input through the synchronizer and track how many samples are valid.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pipe   <= {3{IDLE_LEVEL}};
         primed <= '0;
      end else begin
         pipe   <= {pipe[1:0], async_in};
         primed <= {primed[1:0], 1'b1};
      end
   end

   // Edges are suppressed until the pipe has filled after reset, so a line already
   // away from its idle level at reset release does not look like a fresh edge.
   assign rise = primed[2] &  pipe[1] & ~pipe[2];
   assign fall = primed[2] & ~pipe[1] &  pipe[2];

endmodule

// File: rtl/map_receiver.sv
// Serial maze-map receiver: collects 16-bit cell writes into a shadow map and
// commits the whole shadow to the visible map on a vertical-blanking strobe.
module map_receiver #(
   parameter int                    NUM_CELLS  = map_pkg::NUM_CELLS,
   parameter int                    CELL_W     = map_pkg::CELL_W,
   parameter logic [CELL_W-1:0]     RESET_CELL = map_pkg::RESET_CELL_DEF
) (
   input  logic          clock,
   input  logic          reset,
   map_receiver_if.slave bus
);
   import map_pkg::*;

   localparam int MW = NUM_CELLS * CELL_W;

   logic                          sck_rise;
   logic                          cs_rise;
   logic                          cs_fall;
   logic                          unused_sck_fall;
   logic                          unused_cs_fall_pair;
   logic [1:0]                    sdi_pipe;
   logic                          sdi_d;

   state_t                        state;
   logic [FRAME_BITS-1:0]         shift_q;
   logic [CNT_W-1:0]              cnt_q;
   logic [0:NUM_CELLS-1][CELL_W-1:0] shadow;  // cell 0 packs into the MSBs
   logic                          dirty;
   logic [MW-1:0]                 map_q;
   logic [7:0]                    err_q;

   frame_t                        fr;
   logic                          accept;
   logic                          reject;

   sync_edge #(.IDLE_LEVEL(1'b0)) u_sck_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (bus.sck),
      .rise     (sck_rise),
      .fall     (unused_sck_fall)
   );

   sync_edge #(.IDLE_LEVEL(1'b1)) u_cs_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (bus.cs_n),
      .rise     (cs_rise),
      .fall     (cs_fall)
   );

   assign unused_cs_fall_pair = unused_sck_fall;

   // Delay SDI by the synchronizer depth so it lines up with the synced SCK edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) sdi_pipe <= '0;
      else       sdi_pipe <= {sdi_pipe[0], bus.sdi};
   end
   assign sdi_d = sdi_pipe[1];

   assign fr     = frame_t'(shift_q);
   assign accept = (state == ST_CHECK) && (cnt_q == CNT_FULL) &&
                   (int'(fr.idx) < NUM_CELLS) && (fr.rsv == '0);
   assign reject = (state == ST_CHECK) && !accept;

   // Frame FSM, shadow write, commit to the visible map and error counting.
   // NOTE: the shadow map is ordinary flops that must power up to RESET_CELL, so
   // unlike a RAM it is reset explicitly along with the rest of the state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         shadow  <= {NUM_CELLS{RESET_CELL}};
         dirty   <= 1'b0;
         map_q   <= {NUM_CELLS{RESET_CELL}};
         err_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cs_fall) begin
                  state <= ST_SHIFT;
                  cnt_q <= '0;
               end
            end
            ST_SHIFT: begin
               if (sck_rise) begin
                  shift_q <= {shift_q[FRAME_BITS-2:0], sdi_d};
                  if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
               end
               if (cs_rise) state <= ST_CHECK;
            end
            ST_CHECK: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase

         // NOTE: non-blocking assignments make map_q sample the shadow as it was
         // before this cycle's write, and the later dirty<=1 overrides the clear,
         // which is exactly the accept-during-commit behaviour wanted here.
         if (bus.frame_sync && dirty) begin
            map_q <= shadow;
            dirty <= 1'b0;
         end

         if (accept) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
               if (int'(fr.idx) == i) shadow[i] <= CELL_W'(fr.value);
            end
            dirty <= 1'b1;
         end

         if (reject && err_q != 8'hFF) err_q <= err_q + 8'd1;
      end
   end

   assign bus.map_out     = map_q;
   assign bus.update_pend = dirty;
   assign bus.err_cnt     = err_q;

endmodule

// File: tb/tb_map_receiver.sv
// Self-checking bench for map_receiver: reset, directed frames, a vector table,
// commit/write collision, randomized frames against an array model, saturation
// and mid-frame reset.
module tb_map_receiver;
   import map_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #20 clk = ~clk;

   map_receiver_if bus ();
   map_receiver dut (.clock(clk), .reset(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Reference model: per-cell byte arrays for shadow and committed map.
   logic [7:0] sh_m [NUM_CELLS];
   logic [7:0] cm_m [NUM_CELLS];
   bit         dirty_m;
   int         err_m;

   typedef struct {
      logic [15:0] frame;
      int          nbits;
      bit          sync_after;
      logic        exp_pend;
      logic [7:0]  exp_err;
   } vec_t;
   vec_t vecs [9];

   task automatic check(input string name, input logic [MAP_W-1:0] act, input logic [MAP_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [MAP_W-1:0] model_map();
      logic [MAP_W-1:0] m = '0;
      for (int i = 0; i < NUM_CELLS; i++) m = {m[MAP_W-9:0], cm_m[i]};
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_CELLS; i++) begin
         sh_m[i] = 8'h0F;
         cm_m[i] = 8'h0F;
      end
      dirty_m = 0;
      err_m   = 0;
   endtask

   task automatic model_frame(input logic [15:0] f, input int nbits);
      int idx = int'(f[15:11]);
      if (nbits == 16 && idx < NUM_CELLS && f[10:8] == 3'b000) begin
         sh_m[idx] = f[7:0];
         dirty_m   = 1;
      end else if (err_m < 255) begin
         err_m++;
      end
   endtask

   task automatic model_sync();
      if (dirty_m) begin
         for (int i = 0; i < NUM_CELLS; i++) cm_m[i] = sh_m[i];
         dirty_m = 0;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, " map"},  bus.map_out, model_map());
      check({tag, " pend"}, MAP_W'(bus.update_pend), MAP_W'(dirty_m));
      check({tag, " err"},  MAP_W'(bus.err_cnt), MAP_W'(err_m));
   endtask

   task automatic clocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_frame();
      bus.cs_n = 1'b0;
      clocks(4);
   endtask

   task automatic send_bit(input logic b);
      bus.sdi = b;
      clocks(4);
      bus.sck = 1'b1;
      clocks(4);
      bus.sck = 1'b0;
   endtask

   // Raise CS_N; optionally pulse FRAME_SYNC on the cycle the frame is judged
   // (CS_N through two sync flops, one edge-detect cycle, one cycle in SHIFT->CHECK).
   task automatic end_frame(input bit sync_at_check);
      clocks(4);
      bus.cs_n = 1'b1;
      if (sync_at_check) begin
         clocks(3);
         bus.frame_sync = 1'b1;
         clocks(1);
         bus.frame_sync = 1'b0;
         clocks(4);
      end else begin
         clocks(8);
      end
   endtask

   task automatic send_frame(input logic [15:0] f, input int nbits, input bit sync_at_check);
      start_frame();
      for (int i = 0; i < nbits; i++) send_bit((i < 16) ? f[15-i] : 1'b0);
      end_frame(sync_at_check);
   endtask

   task automatic pulse_sync();
      bus.frame_sync = 1'b1;
      clocks(1);
      bus.frame_sync = 1'b0;
      clocks(2);
   endtask

   initial begin
      logic [15:0] f;
      logic [MAP_W-1:0] rst_map;
      int nb;
      bit coincide;

      rst_map = {NUM_CELLS{8'h0F}};
      vecs[0] = '{16'hA8FF, 16, 1'b0, 1'b0, 8'd1};  // index 21
      vecs[1] = '{16'h0113, 16, 1'b0, 1'b0, 8'd2};  // reserved != 0
      vecs[2] = '{16'h1055, 15, 1'b0, 1'b0, 8'd3};  // short frame
      vecs[3] = '{16'h1055, 17, 1'b0, 1'b0, 8'd4};  // long frame
      vecs[4] = '{16'h2877, 16, 1'b0, 1'b1, 8'd4};  // cell 5 <- 77
      vecs[5] = '{16'h28AA, 16, 1'b0, 1'b1, 8'd4};  // cell 5 <- AA, last wins
      vecs[6] = '{16'h0000,  0, 1'b0, 1'b1, 8'd5};  // no clocks at all
      vecs[7] = '{16'hA0C3, 16, 1'b1, 1'b0, 8'd5};  // cell 20 (last) <- C3, commit
      vecs[8] = '{16'hFFFF, 16, 1'b1, 1'b0, 8'd6};  // reject, sync with dirty clear

      rst = 1'b1;
      bus.sck = 1'b0;
      bus.sdi = 1'b0;
      bus.cs_n = 1'b1;
      bus.frame_sync = 1'b0;
      model_reset();
      clocks(3);
      check("reset map",  bus.map_out, rst_map);
      check("reset pend", MAP_W'(bus.update_pend), '0);
      check("reset err",  MAP_W'(bus.err_cnt), '0);
      rst = 1'b0;
      clocks(4);

      // Single accepted write, then commit.
      send_frame(16'h1013, 16, 0);
      model_frame(16'h1013, 16);
      check("w1 pend", MAP_W'(bus.update_pend), MAP_W'(1));
      check("w1 map held", bus.map_out, rst_map);
      pulse_sync();
      model_sync();
      check("w1 cell2", MAP_W'(bus.map_out[151:144]), MAP_W'(8'h13));
      check("w1 pend clr", MAP_W'(bus.update_pend), '0);

      // Vector table.
      for (int v = 0; v < 9; v++) begin
         send_frame(vecs[v].frame, vecs[v].nbits, 0);
         model_frame(vecs[v].frame, vecs[v].nbits);
         if (vecs[v].sync_after) begin
            pulse_sync();
            model_sync();
         end
         check($sformatf("vec%0d pend", v), MAP_W'(bus.update_pend), MAP_W'(vecs[v].exp_pend));
         check($sformatf("vec%0d err", v),  MAP_W'(bus.err_cnt), MAP_W'(vecs[v].exp_err));
         check($sformatf("vec%0d map", v),  bus.map_out, model_map());
      end
      check("vec cell5", MAP_W'(bus.map_out[127:120]), MAP_W'(8'hAA));

      // Accept coinciding with commit: the commit takes the pre-write shadow.
      send_frame(16'h0093, 16, 0);
      model_frame(16'h0093, 16);
      send_frame(16'h203B, 16, 1);
      model_sync();
      model_frame(16'h203B, 16);
      check("coll cell0", MAP_W'(bus.map_out[167:160]), MAP_W'(8'h93));
      check("coll cell4", MAP_W'(bus.map_out[135:128]), MAP_W'(8'h0F));
      check("coll pend",  MAP_W'(bus.update_pend), MAP_W'(1));
      pulse_sync();
      model_sync();
      check("coll cell4 late", MAP_W'(bus.map_out[135:128]), MAP_W'(8'h3B));

      // Randomized frames against the model.
      for (int k = 0; k < 40; k++) begin
         f[15:11] = 5'($urandom_range(0, 23));
         f[10:8]  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         f[7:0]   = 8'($urandom);
         case ($urandom_range(0, 9))
            0:       nb = 15;
            1:       nb = 17;
            default: nb = 16;
         endcase
         coincide = ($urandom_range(0, 4) == 0);
         send_frame(f, nb, coincide);
         if (coincide) model_sync();
         model_frame(f, nb);
         check_all($sformatf("rnd%0d", k));
         if ($urandom_range(0, 2) == 0) begin
            pulse_sync();
            model_sync();
            check_all($sformatf("rnd%0d sync", k));
         end
      end

      // Error counter saturation.
      for (int k = 0; k < 300; k++) begin
         send_frame(16'h8000, 1, 0);
         model_frame(16'h8000, 1);
      end
      check("err sat", MAP_W'(bus.err_cnt), MAP_W'(8'd255));
      check_all("sat");

      // Reset mid-frame, release with CS_N low, finish the orphaned frame.
      start_frame();
      for (int i = 0; i < 8; i++) send_bit(1'b0);
      rst = 1'b1;
      clocks(2);
      model_reset();
      check("mid rst map",  bus.map_out, rst_map);
      check("mid rst pend", MAP_W'(bus.update_pend), '0);
      check("mid rst err",  MAP_W'(bus.err_cnt), '0);
      rst = 1'b0;
      clocks(2);
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      end_frame(0);
      check("orphan err",  MAP_W'(bus.err_cnt), '0);
      check("orphan pend", MAP_W'(bus.update_pend), '0);
      send_frame(16'h1044, 16, 0);
      model_frame(16'h1044, 16);
      check("post rst pend", MAP_W'(bus.update_pend), MAP_W'(1));
      check_all("post rst");
      pulse_sync();
      model_sync();
      check("post rst cell2", MAP_W'(bus.map_out[151:144]), MAP_W'(8'h44));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
